pc_seq_ctrl: RTL and testbench

- Next-PC sequencer and fetch controller for the RV32I single-cycle core.
- Drives the present-PC input of the program counter register and samples that register's output as pc_i.
- Selects the next PC from sequential, branch, jump, trap-vector, trap-return and hold sources, and sequences boot, flush and halt.
- Keeps the exception PC and a count of retired instructions.

---
 rtl/pc_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer and fetch controller for the RV32I single-cycle core.
// Picks the value the PC register loads next. It also sequences boot, flush
// and halt, and keeps the exception PC, the trap cause and a retire count.
module pc_seq_ctrl #(
    parameter int unsigned           PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]   BOOT_ADDR   = 32'h0000_0000,
    parameter logic [PC_WIDTH-1:0]   TRAP_VEC    = 32'h0000_0100,
    parameter int unsigned           BOOT_CYCLES = 2,
    parameter int unsigned           CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [PC_WIDTH-1:0]  pc_i,
    input  logic                 stall_i,
    input  logic                 branch_taken_i,
    input  logic [PC_WIDTH-1:0]  branch_target_i,
    input  logic                 jump_i,
    input  logic [PC_WIDTH-1:0]  jump_target_i,
    input  logic                 trap_i,
    input  logic                 mret_i,
    input  logic                 halt_i,
    input  logic                 resume_i,
    output logic [PC_WIDTH-1:0]  pc_present_o,
    output logic                 fetch_en_o,
    output logic [PC_WIDTH-1:0]  epc_o,
    output logic                 cause_o,
    output logic                 misalign_o,
    output logic [CNT_WIDTH-1:0] retire_cnt_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          boot_cnt_q, boot_cnt_d;
    logic [PC_WIDTH-1:0]  epc_q, epc_d;
    logic                 cause_q, cause_d;
    logic [CNT_WIDTH-1:0] retire_q, retire_d;

    logic [PC_WIDTH-1:0]  redir_target;
    logic                 redir_misaligned;

    // Jump outranks branch, so the jump target is the one checked for alignment.
    always_comb begin
        redir_target     = jump_i ? jump_target_i : branch_target_i;
        redir_misaligned = (jump_i || branch_taken_i) && (redir_target[1:0] != 2'b00);
    end

    // Next-state, next-PC and bookkeeping updates; one RUN action per cycle, by priority.
    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        retire_d     = retire_q;
        pc_present_o = pc_i;
        fetch_en_o   = 1'b0;
        misalign_o   = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                pc_present_o = BOOT_ADDR;
                if (boot_cnt_q == 32'(BOOT_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 32'd1;
                end
            end
            ST_RUN: begin
                fetch_en_o = 1'b1;
                if (trap_i) begin
                    pc_present_o = TRAP_VEC;
                    epc_d        = pc_i;
                    cause_d      = 1'b0;
                    state_d      = ST_FLUSH;
                end else if (stall_i) begin
                    pc_present_o = pc_i;
                end else if (redir_misaligned) begin
                    pc_present_o = TRAP_VEC;
                    epc_d        = pc_i;
                    cause_d      = 1'b1;
                    misalign_o   = 1'b1;
                    state_d      = ST_FLUSH;
                end else begin
                    // Every remaining action retires the current instruction.
                    retire_d = retire_q + CNT_WIDTH'(1);
                    if (halt_i) begin
                        pc_present_o = pc_i;
                        state_d      = ST_HALT;
                    end else if (mret_i) begin
                        pc_present_o = epc_q;
                        state_d      = ST_FLUSH;
                    end else if (jump_i) begin
                        pc_present_o = jump_target_i;
                    end else if (branch_taken_i) begin
                        pc_present_o = branch_target_i;
                    end else begin
                        pc_present_o = pc_i + PC_WIDTH'(4);
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            ST_HALT: begin
                if (resume_i) begin
                    pc_present_o = pc_i + PC_WIDTH'(4);
                    state_d      = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State, boot counter, exception PC, cause and retire count; reset drops everything at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            epc_q      <= '0;
            cause_q    <= 1'b0;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            retire_q   <= retire_d;
        end
    end

    assign epc_o        = epc_q;
    assign cause_o      = cause_q;
    assign retire_cnt_o = retire_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed scenarios plus random stimulus, checked
// cycle by cycle against a behavioural model of the sequencer.
module tb_pc_seq_ctrl;

    localparam logic [31:0] BOOT_A = 32'h0000_0000;
    localparam logic [31:0] TVEC   = 32'h0000_0100;
    localparam int          BCYC   = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] pc_i, branch_target_i, jump_target_i;
    logic        stall_i, branch_taken_i, jump_i, trap_i, mret_i, halt_i, resume_i;
    logic [31:0] pc_present_o, epc_o, retire_cnt_o;
    logic        fetch_en_o, cause_o, misalign_o;
    logic [1:0]  state_o;

    pc_seq_ctrl #(
        .PC_WIDTH(32), .BOOT_ADDR(BOOT_A), .TRAP_VEC(TVEC),
        .BOOT_CYCLES(BCYC), .CNT_WIDTH(32)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .pc_i(pc_i), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i), .trap_i(trap_i),
        .mret_i(mret_i), .halt_i(halt_i), .resume_i(resume_i),
        .pc_present_o(pc_present_o), .fetch_en_o(fetch_en_o), .epc_o(epc_o),
        .cause_o(cause_o), .misalign_o(misalign_o), .retire_cnt_o(retire_cnt_o),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_bad = 0;

    // Behavioural model: 0=BOOT 1=RUN 2=FLUSH 3=HALT
    int          m_state;
    int          m_boot;
    logic [31:0] m_epc, m_cnt;
    logic        m_cause;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        stall_i = 0; branch_taken_i = 0; jump_i = 0; trap_i = 0;
        mret_i = 0; halt_i = 0; resume_i = 0;
        branch_target_i = 0; jump_target_i = 0;
    endtask

    task automatic model_reset();
        m_state = 0; m_boot = 0; m_epc = 0; m_cause = 0; m_cnt = 0;
    endtask

    // Inputs are already set; compare against the model, then advance one edge.
    task automatic step();
        logic [31:0] e_pc, tgt;
        logic        e_fe, e_mis, redir;
        int          n_state;
        e_pc = pc_i; e_fe = 0; e_mis = 0; n_state = m_state;
        #1;
        chk("state", 32'(state_o), 32'(m_state));
        chk("epc", epc_o, m_epc);
        chk("cause", 32'(cause_o), 32'(m_cause));
        chk("retire", retire_cnt_o, m_cnt);
        redir = jump_i | branch_taken_i;
        tgt   = jump_i ? jump_target_i : branch_target_i;
        case (m_state)
            0: begin
                e_pc = BOOT_A;
                if (m_boot == BCYC - 1) begin n_state = 1; m_boot = 0; end
                else m_boot++;
            end
            1: begin
                e_fe = 1;
                if (trap_i) begin
                    e_pc = TVEC; m_epc = pc_i; m_cause = 0; n_state = 2;
                end else if (stall_i) begin
                    e_pc = pc_i;
                end else if (redir && (tgt % 4 != 0)) begin
                    e_pc = TVEC; m_epc = pc_i; m_cause = 1; e_mis = 1; n_state = 2;
                end else begin
                    m_cnt = m_cnt + 1;
                    if (halt_i) n_state = 3;
                    else if (mret_i) begin e_pc = m_epc; n_state = 2; end
                    else if (jump_i) e_pc = jump_target_i;
                    else if (branch_taken_i) e_pc = branch_target_i;
                    else e_pc = pc_i + 32'd4;
                end
            end
            2: n_state = 1;
            default: if (resume_i) begin e_pc = pc_i + 32'd4; n_state = 1; end
        endcase
        chk("pc_present", pc_present_o, e_pc);
        chk("fetch_en", 32'(fetch_en_o), 32'(e_fe));
        chk("misalign", 32'(misalign_o), 32'(e_mis));
        @(posedge clk_i);
        m_state = n_state;
        @(negedge clk_i);
    endtask

    task automatic rand_inputs();
        logic [31:0] r;
        r = $urandom;
        trap_i         = ($urandom_range(0, 9) == 0);
        stall_i        = ($urandom_range(0, 4) == 0);
        halt_i         = ($urandom_range(0, 9) == 0);
        resume_i       = ($urandom_range(0, 2) == 0);
        mret_i         = ($urandom_range(0, 9) == 0);
        jump_i         = ($urandom_range(0, 3) == 0);
        branch_taken_i = ($urandom_range(0, 3) == 0);
        jump_target_i   = {r[31:2], (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00)};
        branch_target_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} |
                          32'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0);
        pc_i = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    endtask

    initial begin
        clr();
        pc_i   = 0;
        rst_ni = 0;
        model_reset();
        #2;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_pc", pc_present_o, BOOT_A);
        chk("rst_fe", 32'(fetch_en_o), 32'd0);
        chk("rst_mis", 32'(misalign_o), 32'd0);
        chk("rst_cnt", retire_cnt_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        // Boot, then first sequential fetch from 0
        for (int i = 0; i < BCYC; i++) step();
        pc_i = 0; step();
        // Stall masks the jump, then the jump goes through
        pc_i = 32'h40; stall_i = 1; jump_i = 1; jump_target_i = 32'h80; step();
        stall_i = 0; step();
        // Misaligned branch target traps
        clr(); pc_i = 32'h20; branch_taken_i = 1; branch_target_i = 32'h32; step();
        clr(); pc_i = TVEC; step();
        step();
        // Trap beats jump; mret returns to the saved PC
        pc_i = 32'h10; trap_i = 1; jump_i = 1; jump_target_i = 32'h200; step();
        clr(); pc_i = TVEC; step();
        step();
        mret_i = 1; step();
        clr(); pc_i = 32'h10; step();
        // Halt, hold, resume
        pc_i = 32'h60; halt_i = 1; step();
        clr(); trap_i = 1; mret_i = 1; jump_i = 1; jump_target_i = 32'h300;
        for (int i = 0; i < 3; i++) step();
        clr(); resume_i = 1; step();
        // Sequential wrap at the top of the address space
        clr(); pc_i = 32'hFFFF_FFFC; step();
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        // Return to RUN, enter HALT, then reset mid-HALT
        clr(); resume_i = 1; pc_i = 32'h500;
        for (int i = 0; i < 4 && m_state != 1; i++) step();
        clr(); pc_i = 32'h600; halt_i = 1; step();
        clr(); step();
        rst_ni = 0;
        model_reset();
        #1;
        chk("mid_rst_state", 32'(state_o), 32'd0);
        chk("mid_rst_pc", pc_present_o, BOOT_A);
        chk("mid_rst_fe", 32'(fetch_en_o), 32'd0);
        chk("mid_rst_epc", epc_o, 32'd0);
        chk("mid_rst_cause", 32'(cause_o), 32'd0);
        chk("mid_rst_cnt", retire_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1;
        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            step();
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
